// File: rtl/seq_alu.sv
// Handshaked EX-stage ALU: single-cycle RV32I ops plus optional iterative RV32M
// multiply/divide, enabled by defining SEQ_ALU_MULDIV_EN.
module seq_alu #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_UNROLL = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic             i_Flush,
  input  logic [4:0]       i_Operation,
  input  logic [WIDTH-1:0] i_Op1,
  input  logic [WIDTH-1:0] i_Op2,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Result,
  output logic             o_Zero,
  output logic             o_Illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  if ((WIDTH < 16) || ((WIDTH & (WIDTH - 1)) != 0) ||
      !((MUL_UNROLL == 1) || (MUL_UNROLL == 2) || (MUL_UNROLL == 4)) ||
      ((WIDTH % MUL_UNROLL) != 0)) begin : g_bad_cfg
    $error("seq_alu: unsupported WIDTH/MUL_UNROLL combination");
  end

`ifdef SEQ_ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  localparam int unsigned     MUL_STEPS = WIDTH / MUL_UNROLL;
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
`else
  typedef enum logic {S_IDLE, S_DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic             accept_c;
  logic [SHW-1:0]   shamt_c;
  logic [WIDTH-1:0] base_res_c;
  logic             base_ill_c;

  assign o_Ready   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept_c  = i_Valid && o_Ready && !i_Flush;
  assign o_Valid   = valid_q;
  assign o_Result  = result_q;
  assign o_Illegal = illegal_q;
  assign o_Zero    = (result_q == '0);
  assign shamt_c   = i_Op2[SHW-1:0];

  // Single-cycle integer ops, evaluated straight off the request operands
  always_comb begin : base_alu
    base_res_c = '0;
    base_ill_c = 1'b0;
    case (i_Operation[3:0])
      ALU_ADD:   base_res_c = i_Op1 + i_Op2;
      ALU_SUB:   base_res_c = i_Op1 - i_Op2;
      ALU_SLL:   base_res_c = i_Op1 << shamt_c;
      ALU_SLT:   base_res_c = WIDTH'($signed(i_Op1) < $signed(i_Op2));
      ALU_SLTU:  base_res_c = WIDTH'(i_Op1 < i_Op2);
      ALU_XOR:   base_res_c = i_Op1 ^ i_Op2;
      ALU_SRL:   base_res_c = i_Op1 >> shamt_c;
      ALU_SRA:   base_res_c = $unsigned($signed(i_Op1) >>> shamt_c);
      ALU_OR:    base_res_c = i_Op1 | i_Op2;
      ALU_AND:   base_res_c = i_Op1 & i_Op2;
      ALU_LUI:   base_res_c = {i_Op2[WIDTH-13:0], 12'h000};
      ALU_AUIPC: base_res_c = {i_Op2[WIDTH-13:0], 12'h000} + i_Op1;
      default:   base_ill_c = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mul_acc_c;
  logic [WIDTH-1:0]   mplier_q, mplier_d, quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   quo_n_c, rem_n_c, div_res_c;
  logic [WIDTH:0]     div_shift_c, div_diff_c;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [1:0]         fn_q, fn_d;
  logic               bsgn_q, bsgn_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic               mul_last_c, div_last_c, div_sgn_c, op1_neg_c, op2_neg_c;
  logic               div_zero_c, div_ovf_c, asgn_c;

  assign mul_last_c = (cnt_q == SHW'(MUL_STEPS - 1));
  assign div_last_c = (cnt_q == SHW'(WIDTH - 1));
  assign div_sgn_c  = ~i_Operation[0];
  assign op1_neg_c  = div_sgn_c & i_Op1[WIDTH-1];
  assign op2_neg_c  = div_sgn_c & i_Op2[WIDTH-1];
  assign div_zero_c = (i_Op2 == '0);
  assign div_ovf_c  = div_sgn_c && (i_Op1 == MIN_VAL) && (i_Op2 == '1);
  assign asgn_c     = (i_Operation[2:0] == 3'b001) || (i_Operation[2:0] == 3'b010);

  // Retire MUL_UNROLL multiplier bits; a signed multiplier's MSB carries negative weight
  always_comb begin : mul_step
    mul_acc_c = acc_q;
    for (int j = 0; j < int'(MUL_UNROLL); j++) begin
      if (mplier_q[j]) begin
        if (bsgn_q && mul_last_c && (j == int'(MUL_UNROLL) - 1)) begin
          mul_acc_c = mul_acc_c - (mcand_q << j);
        end else begin
          mul_acc_c = mul_acc_c + (mcand_q << j);
        end
      end
    end
  end

  // One restoring-divide step plus the final sign fix-up
  always_comb begin : div_step
    div_shift_c = {rem_q, quo_q[WIDTH-1]};
    div_diff_c  = div_shift_c - {1'b0, dvsr_q};
    if (!div_diff_c[WIDTH]) begin
      rem_n_c = div_diff_c[WIDTH-1:0];
      quo_n_c = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_n_c = div_shift_c[WIDTH-1:0];
      quo_n_c = {quo_q[WIDTH-2:0], 1'b0};
    end
    if (fn_q[1]) div_res_c = neg_rem_q ? -rem_n_c : rem_n_c;
    else         div_res_c = neg_quo_q ? -quo_n_c : quo_n_c;
  end
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin : state_reg
    if (!i_Rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    if (i_Flush) begin
      state_d = S_IDLE;
    end else if (accept_c) begin
      state_d = S_DONE;
`ifdef SEQ_ALU_MULDIV_EN
      if (i_Operation[4]) begin
        if (!i_Operation[2])              state_d = S_MUL;
        else if (!div_zero_c && !div_ovf_c) state_d = S_DIV;
      end
`endif
    end else begin
      case (state_q)
`ifdef SEQ_ALU_MULDIV_EN
        S_MUL:   if (mul_last_c) state_d = S_DONE;
        S_DIV:   if (div_last_c) state_d = S_DONE;
`endif
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin : outputs
    valid_d   = 1'b0;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef SEQ_ALU_MULDIV_EN
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    fn_d      = fn_q;
    bsgn_d    = bsgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    if (accept_c) begin
      if (!i_Operation[4]) begin
        valid_d   = 1'b1;
        result_d  = base_ill_c ? '0 : base_res_c;
        illegal_d = base_ill_c;
      end else begin
`ifdef SEQ_ALU_MULDIV_EN
        illegal_d = 1'b0;
        cnt_d     = '0;
        fn_d      = i_Operation[1:0];
        if (!i_Operation[2]) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{asgn_c & i_Op1[WIDTH-1]}}, i_Op1};
          mplier_d = i_Op2;
          bsgn_d   = (i_Operation[2:0] == 3'b001);
        end else if (div_zero_c) begin
          valid_d  = 1'b1;
          result_d = i_Operation[1] ? i_Op1 : '1;
        end else if (div_ovf_c) begin
          valid_d  = 1'b1;
          result_d = i_Operation[1] ? '0 : MIN_VAL;
        end else begin
          quo_d     = op1_neg_c ? -i_Op1 : i_Op1;
          dvsr_d    = op2_neg_c ? -i_Op2 : i_Op2;
          rem_d     = '0;
          neg_quo_d = op1_neg_c ^ op2_neg_c;
          neg_rem_d = op1_neg_c;
        end
`else
        valid_d   = 1'b1;
        result_d  = '0;
        illegal_d = 1'b1;
`endif
      end
    end else if (!i_Flush) begin
`ifdef SEQ_ALU_MULDIV_EN
      case (state_q)
        S_MUL: begin
          acc_d    = mul_acc_c;
          mcand_d  = mcand_q << MUL_UNROLL;
          mplier_d = mplier_q >> MUL_UNROLL;
          cnt_d    = cnt_q + SHW'(1);
          if (mul_last_c) begin
            valid_d  = 1'b1;
            result_d = (fn_q == 2'b00) ? mul_acc_c[WIDTH-1:0] : mul_acc_c[2*WIDTH-1:WIDTH];
          end
        end
        S_DIV: begin
          quo_d = quo_n_c;
          rem_d = rem_n_c;
          cnt_d = cnt_q + SHW'(1);
          if (div_last_c) begin
            valid_d  = 1'b1;
            result_d = div_res_c;
          end
        end
        default: ;
      endcase
`endif
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin : data_regs
    if (!i_Rst_n) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      fn_q      <= '0;
      bsgn_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifdef SEQ_ALU_MULDIV_EN
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      fn_q      <= fn_d;
      bsgn_q    <= bsgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

endmodule
